camara_scan_ctrl: RTL and testbench

Sequencer for the product-recognition camera on the supermarket scale. It waits for a settled load on the pan, enables the camera, and debounces the 3-bit product code from modulo_camara. It then hands a validated {code, weight} item to the pricing logic over a valid/ack handshake. The block rearms only after the pan is emptied, and flags a scan error when no product is recognised in time.

---
 rtl/camara_scan_ctrl.sv | 175 +++++++++++++++++
 tb/tb_camara_scan_ctrl.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/camara_scan_ctrl.sv
// Scale camera sequencer: settle on a load, debounce the product code, hand off {code, weight}.
// Optional macro SCAN_RETRY_EN: first recognition timeout re-settles once instead of erroring.
module camara_scan_ctrl #(
  parameter int WEIGHT_W   = 16,
  parameter int MIN_WEIGHT = 10,
  parameter int TOL        = 2,
  parameter int SETTLE_CYC = 8,
  parameter int MATCH_N    = 3,
  parameter int TIMEOUT    = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [WEIGHT_W-1:0] weight,
  input  logic [2:0]          product_detected,
  input  logic                item_ack,
  output logic                cam_en,
  output logic                item_valid,
  output logic [2:0]          item_code,
  output logic [WEIGHT_W-1:0] item_weight,
  output logic                busy,
  output logic                scan_error
);
  localparam int SW = $clog2(SETTLE_CYC + 1);
  localparam int MW = $clog2(MATCH_N + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [SW-1:0]       STAB_LAST  = SW'(SETTLE_CYC - 1);
  localparam logic [MW-1:0]       MATCH_LAST = MW'(MATCH_N - 1);
  localparam logic [TW-1:0]       TIME_LAST  = TW'(TIMEOUT - 1);
  localparam logic [WEIGHT_W-1:0] MIN_W      = WEIGHT_W'(MIN_WEIGHT);
  localparam logic [WEIGHT_W:0]   TOL_W      = (WEIGHT_W+1)'(TOL);

  typedef enum logic [2:0] {
    ST_IDLE, ST_SETTLE, ST_CAPTURE, ST_REPORT, ST_WAIT_CLEAR, ST_ERROR
  } state_t;

  state_t              state;
  logic [WEIGHT_W-1:0] ref_weight;
  logic [SW-1:0]       stab_cnt;
  logic [MW-1:0]       match_cnt;
  logic [TW-1:0]       timer;
  logic [2:0]          last_code;
  logic [WEIGHT_W:0]   diff;
  logic                present, stable, code_seen, code_same, accept;
`ifdef SCAN_RETRY_EN
  logic                retry_used;
`endif

  assign present   = weight >= MIN_W;
  // Widened difference so a reading far below ref cannot wrap into "stable".
  assign diff      = (weight >= ref_weight) ? ({1'b0, weight} - {1'b0, ref_weight})
                                            : ({1'b0, ref_weight} - {1'b0, weight});
  assign stable    = diff <= TOL_W;
  assign code_seen = product_detected != 3'd0;
  assign code_same = product_detected == last_code;
  assign accept    = code_seen && (code_same ? (match_cnt == MATCH_LAST) : (MATCH_N == 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      ref_weight  <= '0;
      stab_cnt    <= '0;
      match_cnt   <= '0;
      timer       <= '0;
      last_code   <= '0;
      cam_en      <= 1'b0;
      item_valid  <= 1'b0;
      item_code   <= '0;
      item_weight <= '0;
      busy        <= 1'b0;
      scan_error  <= 1'b0;
`ifdef SCAN_RETRY_EN
      retry_used  <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
`ifdef SCAN_RETRY_EN
          retry_used <= 1'b0;
`endif
          if (present) begin
            state      <= ST_SETTLE;
            ref_weight <= weight;
            stab_cnt   <= '0;
            busy       <= 1'b1;
          end
        end
        ST_SETTLE: begin
          if (!present) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else if (!stable) begin
            ref_weight <= weight;
            stab_cnt   <= '0;
          end else if (stab_cnt == STAB_LAST) begin
            state       <= ST_CAPTURE;
            item_weight <= ref_weight;
            timer       <= '0;
            match_cnt   <= '0;
            last_code   <= '0;
            cam_en      <= 1'b1;
          end else begin
            stab_cnt <= stab_cnt + 1'b1;
          end
        end
        ST_CAPTURE: begin
          timer <= timer + 1'b1;
          if (!present) begin
            state  <= ST_IDLE;
            cam_en <= 1'b0;
            busy   <= 1'b0;
          end else begin
            if (code_seen && code_same) begin
              match_cnt <= match_cnt + 1'b1;
            end else if (code_seen) begin
              last_code <= product_detected;
              match_cnt <= MW'(1);
            end else begin
              match_cnt <= '0;
              last_code <= '0;
            end
            // An accept wins over a timeout landing on the same cycle.
            if (accept) begin
              state      <= ST_REPORT;
              item_code  <= product_detected;
              cam_en     <= 1'b0;
              item_valid <= 1'b1;
            end else if (timer == TIME_LAST) begin
              cam_en <= 1'b0;
`ifdef SCAN_RETRY_EN
              if (!retry_used) begin
                retry_used <= 1'b1;
                state      <= ST_SETTLE;
                ref_weight <= weight;
                stab_cnt   <= '0;
              end else begin
                state      <= ST_ERROR;
                scan_error <= 1'b1;
              end
`else
              state      <= ST_ERROR;
              scan_error <= 1'b1;
`endif
            end
          end
        end
        ST_REPORT: begin
          if (item_ack) begin
            state      <= ST_WAIT_CLEAR;
            item_valid <= 1'b0;
          end
        end
        ST_WAIT_CLEAR: begin
          if (!present) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end
        ST_ERROR: begin
          if (!present) begin
            state      <= ST_IDLE;
            busy       <= 1'b0;
            scan_error <= 1'b0;
          end
        end
        default: begin
          state      <= ST_IDLE;
          cam_en     <= 1'b0;
          item_valid <= 1'b0;
          busy       <= 1'b0;
          scan_error <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_camara_scan_ctrl.sv
// Directed bench for camara_scan_ctrl; reported items are checked by a queue-driven monitor.
module tb_camara_scan_ctrl;
  localparam int WW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [WW-1:0] weight = '0;
  logic [2:0]    product_detected = '0;
  logic          item_ack = 1'b0;
  logic          cam_en, item_valid, busy, scan_error;
  logic [2:0]    item_code;
  logic [WW-1:0] item_weight;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [2:0]    code;
    logic [WW-1:0] w;
  } item_t;
  item_t exp_q[$];
  logic  mon_prev = 1'b0;

  camara_scan_ctrl dut (
    .clk(clk), .rst_n(rst_n), .weight(weight), .product_detected(product_detected),
    .item_ack(item_ack), .cam_en(cam_en), .item_valid(item_valid), .item_code(item_code),
    .item_weight(item_weight), .busy(busy), .scan_error(scan_error)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  function automatic logic sig(input int sel);
    case (sel)
      0:       return cam_en;
      1:       return item_valid;
      2:       return scan_error;
      default: return !cam_en;
    endcase
  endfunction

  // Steps until the selected output is high; the step count must equal exp_n.
  task automatic wait_for(input string nm, input int sel, input int exp_n);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (!sig(sel) && n < 400);
    check(nm, n, exp_n);
  endtask

  // Monitor: every rising item_valid pops one expected item.
  initial begin
    forever begin
      @(negedge clk);
      if (item_valid && !mon_prev) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_item: got code=%0d weight=%0d, expected none", item_code, item_weight);
        end else begin
          item_t e;
          e = exp_q.pop_front();
          $display("item code=%0d weight=%0d (expected code=%0d weight=%0d)", item_code, item_weight, e.code, e.w);
          check("item_code", int'(item_code), int'(e.code));
          check("item_weight", int'(item_weight), int'(e.w));
        end
      end
      mon_prev = item_valid;
    end
  end

  initial begin
    step(); step();
    check("rst_cam_en", cam_en, 0);
    check("rst_busy", busy, 0);
    check("rst_item_valid", item_valid, 0);
    check("rst_scan_error", scan_error, 0);
    check("rst_item_code", int'(item_code), 0);
    check("rst_item_weight", int'(item_weight), 0);
    rst_n = 1'b1;
    step();
    check("idle_busy", busy, 0);

    // Basic scan: weight sampled at the first edge, then 8 stable settle cycles.
    weight = 16'd500;
    step();
    check("settle_busy", busy, 1);
    check("settle_cam_off", cam_en, 0);
    wait_for("cam_en_delay", 0, 8);
    step(); step();
    product_detected = 3'd5;
    exp_q.push_back('{3'd5, 16'd500});
    wait_for("valid_delay", 1, 3);
    weight = 16'd700;
    step();
    check("report_hold_valid", item_valid, 1);
    check("report_hold_weight", int'(item_weight), 500);
    step();
    item_ack = 1'b1;
    step();
    item_ack = 1'b0;
    check("ack_drop", item_valid, 0);
    product_detected = 3'd0;
    repeat (4) step();
    check("wait_clear_busy", busy, 1);
    check("wait_clear_cam", cam_en, 0);
    weight = 16'd0;
    step();
    check("clear_busy", busy, 0);

    // Settle disturbance: 501/502 within tolerance of 500, 505 restarts settling.
    weight = 16'd500; step();
    weight = 16'd501; step();
    weight = 16'd502; step();
    weight = 16'd505;
    wait_for("disturb_cam_delay", 0, 9);
    // Flicker 3,3,6,6,6: only the trailing 6 run is long enough.
    exp_q.push_back('{3'd6, 16'd505});
    product_detected = 3'd3; step(); step();
    product_detected = 3'd6; step(); step();
    check("flicker_not_yet", item_valid, 0);
    step();
    check("flicker_valid", item_valid, 1);
    item_ack = 1'b1;
    step();
    item_ack = 1'b0;
    product_detected = 3'd0;
    weight = 16'd0;
    step();
    check("flicker_clear_busy", busy, 0);

    // Recognition timeout with nothing detected.
    weight = 16'd200;
    wait_for("to_cam_delay", 0, 9);
`ifdef SCAN_RETRY_EN
    wait_for("retry_cam_drop", 3, 64);
    check("retry_no_error", scan_error, 0);
    check("retry_busy", busy, 1);
    wait_for("retry_resettle", 0, 8);
    wait_for("retry_timeout", 2, 64);
`else
    wait_for("timeout", 2, 64);
`endif
    check("error_cam_off", cam_en, 0);
    check("error_busy", busy, 1);
    repeat (3) step();
    check("error_held", scan_error, 1);
    weight = 16'd0;
    step();
    check("error_clear", scan_error, 0);
    check("error_idle", busy, 0);

    // Removal during capture; ack outside REPORT must be ignored.
    weight = 16'd300;
    item_ack = 1'b1;
    wait_for("rm_cam_delay", 0, 9);
    repeat (10) step();
    check("rm_cam_held", cam_en, 1);
    item_ack = 1'b0;
    weight = 16'd0;
    step();
    check("rm_cam_off", cam_en, 0);
    check("rm_busy", busy, 0);
    check("rm_valid", item_valid, 0);
    check("rm_error", scan_error, 0);
    weight = 16'd300;
    wait_for("fresh_cam_delay", 0, 9);
    product_detected = 3'd2;
    exp_q.push_back('{3'd2, 16'd300});
    wait_for("fresh_valid", 1, 3);
    item_ack = 1'b1;
    step();
    item_ack = 1'b0;
    product_detected = 3'd0;
    weight = 16'd0;
    step();
    check("fresh_clear_busy", busy, 0);

    // Reset mid-capture discards the partially matched code.
    weight = 16'd400;
    wait_for("rst_scan_cam_delay", 0, 9);
    product_detected = 3'd4;
    step(); step();
    rst_n = 1'b0;
    step();
    check("midrst_cam_en", cam_en, 0);
    check("midrst_busy", busy, 0);
    check("midrst_valid", item_valid, 0);
    weight = 16'd0;
    product_detected = 3'd0;
    rst_n = 1'b1;
    repeat (5) step();
    check("post_rst_busy", busy, 0);

    check("queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
